// File: rtl/rv32i_writeback_pkg.sv
// Shared definitions for the RV32I writeback stage: FSM state encodings and
// load funct3 codes used by the FSM and the load aligner.
package rv32i_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DRAIN    = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rv32i_load_align.sv
// Load data aligner: picks the byte/half/word lane from the memory read word
// and sign/zero extends it. legal_o is low for funct3 codes that are not loads.
module rv32i_load_align
    import rv32i_writeback_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lsb_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o,
    output logic        legal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane selection; halfword alignment ignores address bit 0.
    always_comb begin
        byte_v = rdata_i[7:0];
        case (lsb_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            2'd3: byte_v = rdata_i[31:24];
            default: byte_v = rdata_i[7:0];
        endcase
        half_v = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Size/sign decode.
    always_comb begin
        data_o  = 32'd0;
        legal_o = 1'b1;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{16{half_v[15]}}, half_v};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'd0, byte_v};
            F3_LHU:  data_o = {16'd0, half_v};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: registers ALU results and aligned load data onto the
// register file write port, stalling the memory stage while a load waits for
// its ack. Optional load timeout enabled by defining RV32I_WB_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | accepting a new instruction from the memory stage
// ST_WAIT_ACK | load outstanding, rd/funct3/lsb captured, waiting for ack
// ST_DRAIN    | flushed load still outstanding, ack will be discarded
module rv32i_writeback
    import rv32i_writeback_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_flush,
    input  logic        i_is_load,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_alu_rd,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_stall,
    output logic        o_wr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_bus_err
);

    wb_state_e   state_q, state_d;
    logic [4:0]  cap_rd_addr_q, cap_rd_addr_d;
    logic [2:0]  cap_funct3_q, cap_funct3_d;
    logic [1:0]  cap_lsb_q, cap_lsb_d;
    logic        cap_wr_rd_q, cap_wr_rd_d;
    logic        wr_q, wr_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_q, rd_d;
    logic        bus_err_q, bus_err_d;
    logic        timeout_hit;

    logic [2:0]  align_funct3;
    logic [1:0]  align_lsb;
    logic [31:0] align_data;
    logic        align_legal;

    // A new load aligns with live inputs; an outstanding one with the captured fields.
    assign align_funct3 = (state_q == ST_IDLE) ? i_funct3   : cap_funct3_q;
    assign align_lsb    = (state_q == ST_IDLE) ? i_addr_lsb : cap_lsb_q;

    rv32i_load_align u_align (
        .rdata_i  (i_mem_rdata),
        .lsb_i    (align_lsb),
        .funct3_i (align_funct3),
        .data_o   (align_data),
        .legal_o  (align_legal)
    );

`ifdef RV32I_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive busy cycle without an ack.
    assign timeout_hit = (state_q != ST_IDLE) && !i_mem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count busy cycles without ack; anything else (including IDLE) clears it.
    always_comb begin
        cnt_d = '0;
        if ((state_q != ST_IDLE) && !i_mem_ack && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    // Next-state, capture, stall and write-port decode.
    always_comb begin
        state_d       = state_q;
        cap_rd_addr_d = cap_rd_addr_q;
        cap_funct3_d  = cap_funct3_q;
        cap_lsb_d     = cap_lsb_q;
        cap_wr_rd_d   = cap_wr_rd_q;
        wr_d          = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_d          = rd_q;
        bus_err_d     = 1'b0;
        o_stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_ce && !i_flush) begin
                    if (!i_is_load) begin
                        wr_d      = i_wr_rd && (i_rd_addr != 5'd0);
                        rd_addr_d = i_rd_addr;
                        rd_d      = i_alu_rd;
                    end else if (i_mem_ack) begin
                        wr_d      = i_wr_rd && align_legal && (i_rd_addr != 5'd0);
                        rd_addr_d = i_rd_addr;
                        rd_d      = align_data;
                    end else begin
                        cap_rd_addr_d = i_rd_addr;
                        cap_funct3_d  = i_funct3;
                        cap_lsb_d     = i_addr_lsb;
                        cap_wr_rd_d   = i_wr_rd;
                        state_d       = ST_WAIT_ACK;
                        o_stall       = 1'b1;
                    end
                end
            end

            ST_WAIT_ACK: begin
                o_stall = !i_mem_ack;
                if (i_mem_ack) begin
                    state_d = ST_IDLE;
                    if (!i_flush) begin
                        wr_d      = cap_wr_rd_q && align_legal && (cap_rd_addr_q != 5'd0);
                        rd_addr_d = cap_rd_addr_q;
                        rd_d      = align_data;
                    end
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    o_stall   = 1'b0;
                    bus_err_d = 1'b1;
                end else if (i_flush) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                o_stall = !i_mem_ack;
                if (i_mem_ack) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    o_stall   = 1'b0;
                    bus_err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture and output registers; reset abandons any outstanding load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            cap_rd_addr_q <= 5'd0;
            cap_funct3_q  <= 3'd0;
            cap_lsb_q     <= 2'd0;
            cap_wr_rd_q   <= 1'b0;
            wr_q          <= 1'b0;
            rd_addr_q     <= 5'd0;
            rd_q          <= 32'd0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_rd_addr_q <= cap_rd_addr_d;
            cap_funct3_q  <= cap_funct3_d;
            cap_lsb_q     <= cap_lsb_d;
            cap_wr_rd_q   <= cap_wr_rd_d;
            wr_q          <= wr_d;
            rd_addr_q     <= rd_addr_d;
            rd_q          <= rd_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign o_wr      = wr_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd      = rd_q;
    assign o_bus_err = bus_err_q;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed self-checking bench for rv32i_writeback. With RV32I_WB_TIMEOUT_EN
// defined the DUT is built with TIMEOUT_CYCLES=4 and the timeout is exercised.
module tb_rv32i_writeback;

`ifdef RV32I_WB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        flush;
    logic        is_load;
    logic        wr_rd;
    logic [4:0]  rd_addr;
    logic [31:0] alu;
    logic [2:0]  funct3;
    logic [1:0]  lsb;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic        wr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        bus_err;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [31:0] rdata;
        logic [31:0] exp;
        logic        exp_wr;
    } ld_vec_t;

    rv32i_writeback #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ce        (ce),
        .i_flush     (flush),
        .i_is_load   (is_load),
        .i_wr_rd     (wr_rd),
        .i_rd_addr   (rd_addr),
        .i_alu_rd    (alu),
        .i_funct3    (funct3),
        .i_addr_lsb  (lsb),
        .i_mem_rdata (rdata),
        .i_mem_ack   (ack),
        .o_stall     (stall),
        .o_wr        (wr),
        .o_rd_addr   (wr_addr),
        .o_rd        (wr_data),
        .o_bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ce = 0; flush = 0; is_load = 0; wr_rd = 0; rd_addr = 0; alu = 0;
        funct3 = 0; lsb = 0; rdata = 0; ack = 0;
    endtask

    task automatic test_reset();
        checks++; if (wr !== 1'b0) $display("FAIL reset_wr: got %0b want 0", wr); else passed++;
        checks++; if (wr_addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", wr_addr); else passed++;
        checks++; if (wr_data !== 32'd0) $display("FAIL reset_data: got %h want 0", wr_data); else passed++;
        checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %0b want 0", bus_err); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall); else passed++;
    endtask

    task automatic test_alu();
        ce = 1; is_load = 0; wr_rd = 1; rd_addr = 5'd5; alu = 32'h1234_5678;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL alu_stall: got %0b want 0", stall); else passed++;
        cyc();
        rd_addr = 5'd0; alu = 32'hFFFF_0000;
        checks++; if (wr !== 1'b1) $display("FAIL alu_wr: got %0b want 1", wr); else passed++;
        checks++; if (wr_addr !== 5'd5) $display("FAIL alu_addr: got %0d want 5", wr_addr); else passed++;
        checks++; if (wr_data !== 32'h1234_5678) $display("FAIL alu_data: got %h want 12345678", wr_data); else passed++;
        cyc();
        wr_rd = 0; rd_addr = 5'd3; alu = 32'h0000_0033;
        checks++; if (wr !== 1'b0) $display("FAIL alu_rd0_wr: got %0b want 0", wr); else passed++;
        cyc();
        idle_in();
        checks++; if (wr !== 1'b0) $display("FAIL alu_nowr_wr: got %0b want 0", wr); else passed++;
        cyc();
        checks++; if (wr !== 1'b0) $display("FAIL alu_idle_wr: got %0b want 0", wr); else passed++;
    endtask

    task automatic test_load_align();
        ld_vec_t v[$];
        v.push_back('{3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 1'b1});
        v.push_back('{3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080, 1'b1});
        v.push_back('{3'b101, 2'd2, 32'h0080_0000, 32'h0000_0080, 1'b1});
        v.push_back('{3'b001, 2'd3, 32'h8000_1234, 32'hFFFF_8000, 1'b1});
        v.push_back('{3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1});
        v.push_back('{3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F, 1'b1});
        v.push_back('{3'b101, 2'd0, 32'h1234_F00D, 32'h0000_F00D, 1'b1});
        v.push_back('{3'b001, 2'd1, 32'h1234_F00D, 32'hFFFF_F00D, 1'b1});
        v.push_back('{3'b100, 2'd3, 32'hAB00_0000, 32'h0000_00AB, 1'b1});
        v.push_back('{3'b011, 2'd0, 32'h5555_5555, 32'h0000_0000, 1'b0});
        v.push_back('{3'b110, 2'd0, 32'h5555_5555, 32'h0000_0000, 1'b0});
        foreach (v[i]) begin
            ce = 1; is_load = 1; wr_rd = 1; ack = 1; rd_addr = 5'd9;
            funct3 = v[i].f3; lsb = v[i].lsb; rdata = v[i].rdata;
            #1;
            checks++; if (stall !== 1'b0) $display("FAIL ld%0d_stall: got %0b want 0", i, stall); else passed++;
            cyc();
            checks++; if (wr !== v[i].exp_wr) $display("FAIL ld%0d_wr: got %0b want %0b", i, wr, v[i].exp_wr); else passed++;
            if (v[i].exp_wr) begin
                checks++; if (wr_data !== v[i].exp) $display("FAIL ld%0d_data: got %h want %h", i, wr_data, v[i].exp); else passed++;
            end
        end
        idle_in();
        cyc();
        checks++; if (wr !== 1'b0) $display("FAIL ld_end_wr: got %0b want 0", wr); else passed++;
    endtask

    task automatic test_load_wait();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd7; funct3 = 3'b010; lsb = 0; ack = 0;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL wait_stall0: got %0b want 1", stall); else passed++;
        cyc();
        ce = 1; is_load = 0; rd_addr = 5'd12; funct3 = 3'b000; lsb = 2'd3; alu = 32'h7777_7777;
        for (int i = 1; i < 3; i++) begin
            #1;
            checks++; if (stall !== 1'b1) $display("FAIL wait_stall%0d: got %0b want 1", i, stall); else passed++;
            checks++; if (wr !== 1'b0) $display("FAIL wait_wr%0d: got %0b want 0", i, wr); else passed++;
            cyc();
        end
        ack = 1; rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL wait_ack_stall: got %0b want 0", stall); else passed++;
        cyc();
        idle_in();
        checks++; if (wr !== 1'b1) $display("FAIL wait_wr: got %0b want 1", wr); else passed++;
        checks++; if (wr_addr !== 5'd7) $display("FAIL wait_addr: got %0d want 7", wr_addr); else passed++;
        checks++; if (wr_data !== 32'hCAFE_F00D) $display("FAIL wait_data: got %h want cafef00d", wr_data); else passed++;
        cyc();
        checks++; if (wr !== 1'b0) $display("FAIL wait_once: got %0b want 0", wr); else passed++;
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd0; funct3 = 3'b010;
        cyc();
        idle_in();
        ack = 1; rdata = 32'h1111_2222;
        cyc();
        ack = 0;
        checks++; if (wr !== 1'b0) $display("FAIL wait_rd0_wr: got %0b want 0", wr); else passed++;
    endtask

    task automatic test_flush();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd6; funct3 = 3'b010;
        cyc();
        idle_in();
        flush = 1;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL flush_wait_stall: got %0b want 1", stall); else passed++;
        cyc();
        flush = 0;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL flush_drain_stall: got %0b want 1", stall); else passed++;
        cyc();
        ack = 1; rdata = 32'h9999_9999;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_ack_stall: got %0b want 0", stall); else passed++;
        cyc();
        ack = 0;
        checks++; if (wr !== 1'b0) $display("FAIL flush_drain_wr: got %0b want 0", wr); else passed++;
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd6; funct3 = 3'b010;
        cyc();
        idle_in();
        flush = 1; ack = 1; rdata = 32'h8888_8888;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_same_stall: got %0b want 0", stall); else passed++;
        cyc();
        idle_in();
        checks++; if (wr !== 1'b0) $display("FAIL flush_same_wr: got %0b want 0", wr); else passed++;
        ce = 1; flush = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd2; funct3 = 3'b010;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL flush_idle_stall: got %0b want 0", stall); else passed++;
        cyc();
        idle_in();
        ack = 1; rdata = 32'h7777_0000;
        cyc();
        checks++; if (wr !== 1'b0) $display("FAIL stray_ack_wr: got %0b want 0", wr); else passed++;
        ce = 1; is_load = 0; wr_rd = 1; rd_addr = 5'd4; alu = 32'h0000_A5A5; ack = 0;
        cyc();
        idle_in();
        checks++; if (wr !== 1'b1) $display("FAIL flush_alu_wr: got %0b want 1", wr); else passed++;
        checks++; if (wr_addr !== 5'd4) $display("FAIL flush_alu_addr: got %0d want 4", wr_addr); else passed++;
        checks++; if (wr_data !== 32'h0000_A5A5) $display("FAIL flush_alu_data: got %h want 0000a5a5", wr_data); else passed++;
    endtask

    task automatic test_reset_mid();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd8; funct3 = 3'b010;
        cyc();
        idle_in();
        #2;
        rst_n = 0;
        #1;
        checks++; if (wr_data !== 32'd0) $display("FAIL rstmid_data: got %h want 0", wr_data); else passed++;
        checks++; if (wr_addr !== 5'd0) $display("FAIL rstmid_addr: got %0d want 0", wr_addr); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL rstmid_stall: got %0b want 0", stall); else passed++;
        cyc();
        rst_n = 1;
        ack = 1; rdata = 32'h1111_1111;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL rstmid_late_stall: got %0b want 0", stall); else passed++;
        cyc();
        ack = 0;
        checks++; if (wr !== 1'b0) $display("FAIL rstmid_late_wr: got %0b want 0", wr); else passed++;
    endtask

`ifdef RV32I_WB_TIMEOUT_EN
    task automatic test_timeout();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd9; funct3 = 3'b010;
        cyc();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== 1'b1) $display("FAIL to_stall%0d: got %0b want 1", i, stall); else passed++;
            checks++; if (bus_err !== 1'b0) $display("FAIL to_err%0d: got %0b want 0", i, bus_err); else passed++;
            cyc();
        end
        checks++; if (stall !== 1'b0) $display("FAIL to_stall_drop: got %0b want 0", stall); else passed++;
        cyc();
        checks++; if (bus_err !== 1'b1) $display("FAIL to_err_pulse: got %0b want 1", bus_err); else passed++;
        checks++; if (wr !== 1'b0) $display("FAIL to_wr: got %0b want 0", wr); else passed++;
        ack = 1; rdata = 32'h2222_3333;
        cyc();
        ack = 0;
        checks++; if (bus_err !== 1'b0) $display("FAIL to_err_once: got %0b want 0", bus_err); else passed++;
        checks++; if (wr !== 1'b0) $display("FAIL to_late_wr: got %0b want 0", wr); else passed++;
    endtask
`else
    task automatic test_no_timeout();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 5'd10; funct3 = 3'b010;
        cyc();
        idle_in();
        for (int i = 0; i < 20; i++) begin
            cyc();
        end
        checks++; if (stall !== 1'b1) $display("FAIL nto_stall: got %0b want 1", stall); else passed++;
        checks++; if (bus_err !== 1'b0) $display("FAIL nto_err: got %0b want 0", bus_err); else passed++;
        ack = 1; rdata = 32'h0BAD_F00D;
        cyc();
        ack = 0;
        checks++; if (wr !== 1'b1) $display("FAIL nto_wr: got %0b want 1", wr); else passed++;
        checks++; if (wr_data !== 32'h0BAD_F00D) $display("FAIL nto_data: got %h want 0badf00d", wr_data); else passed++;
    endtask
`endif

    initial begin
        idle_in();
        rst_n = 0;
        cyc();
        cyc();
        test_reset();
        rst_n = 1;
        test_alu();
        test_load_align();
        test_load_wait();
        test_flush();
        test_reset_mid();
`ifdef RV32I_WB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
